pipe_mem_dmem_ctrl: RTL and testbench



---
 rtl/pipe_mem_dmem_ctrl.sv | 96 +++++++++
 tb/tb_pipe_mem_dmem_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_dmem_ctrl.sv
// pipe_mem_dmem_ctrl: MEM-stage data-memory req/ack controller with load alignment, stall and timeout
module pipe_mem_dmem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [3:0]  mem_dmem_op,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_rt_data,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic [31:0] mem_dmem_out,
  output logic        mem_stall,
  output logic        mem_addr_exc,
  output logic        mem_bus_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic [3:0] op_r;
  logic [1:0] lo_r;
  logic is_word, is_half, is_byte, is_st, aligned, start, timeout, ld_r;
  logic [3:0] be_n;
  logic [31:0] wdata_n, ld_data;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  assign is_word = mem_dmem_op == 4'd1 || mem_dmem_op == 4'd6;
  assign is_half = mem_dmem_op inside {4'd2, 4'd3, 4'd7};
  assign is_byte = mem_dmem_op inside {4'd4, 4'd5, 4'd8};
  assign is_st = mem_dmem_op inside {[4'd6:4'd8]};
  assign aligned = is_word ? mem_alu_out[1:0] == 2'b00 : is_half ? !mem_alu_out[0] : 1'b1;
  assign start = mem_valid && (is_word || is_half || is_byte) && aligned;
  assign timeout = state == BUSY && !dmem_ack && cnt == 8'(TIMEOUT - 1);
  assign be_n = is_word ? 4'hF : is_half ? (mem_alu_out[1] ? 4'hC : 4'h3) : 4'b0001 << mem_alu_out[1:0];
  assign wdata_n = is_half ? {2{mem_rt_data[15:0]}} : is_byte ? {4{mem_rt_data[7:0]}} : mem_rt_data;
  assign ld_r = op_r inside {[4'd1:4'd5]};
  assign lane_b = 8'(dmem_rdata >> {lo_r, 3'b000});
  assign lane_h = lo_r[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign ld_data = op_r == 4'd2 ? {{16{lane_h[15]}}, lane_h} :
                   op_r == 4'd3 ? {16'h0, lane_h} :
                   op_r == 4'd4 ? {{24{lane_b[7]}}, lane_b} :
                   op_r == 4'd5 ? {24'h0, lane_b} : dmem_rdata;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next-state logic; DONE never re-evaluates start so an instruction issues once
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? BUSY : IDLE;
      BUSY: state_n = (dmem_ack || timeout) ? DONE : BUSY;
      default: state_n = IDLE;
    endcase
  end
  // stall and misalignment outputs
  always_comb begin
    mem_stall = (state == IDLE && start) || state == BUSY;
    mem_addr_exc = state == IDLE && mem_valid && (is_word || is_half || is_byte) && !aligned;
  end
  // bus latches, wait counter, load result and error pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_be <= '0;
      mem_dmem_out <= '0;
      mem_bus_err <= 1'b0;
      cnt <= '0;
      op_r <= '0;
      lo_r <= '0;
    end else begin
      dmem_req <= state_n == BUSY;
      mem_bus_err <= timeout;
      if (state == IDLE && start) begin
        dmem_we <= is_st;
        dmem_addr <= {mem_alu_out[31:2], 2'b00};
        dmem_wdata <= wdata_n;
        dmem_be <= be_n;
        op_r <= mem_dmem_op;
        lo_r <= mem_alu_out[1:0];
        cnt <= '0;
      end
      if (state == BUSY) cnt <= cnt + 8'd1;
      if (state == BUSY && dmem_ack && ld_r) mem_dmem_out <= ld_data;
      else if (timeout) mem_dmem_out <= '0;
    end
endmodule

// File: tb/tb_pipe_mem_dmem_ctrl.sv
// tb_pipe_mem_dmem_ctrl: scoreboard bench for the MEM-stage data-memory controller
module tb_pipe_mem_dmem_ctrl;
  logic clk = 0, rst = 0, mem_valid = 0, dmem_ack = 0;
  logic [3:0] mem_dmem_op = 0;
  logic [31:0] mem_alu_out = 0, mem_rt_data = 0, dmem_rdata = 0;
  logic dmem_req, dmem_we, mem_stall, mem_addr_exc, mem_bus_err;
  logic [31:0] dmem_addr, dmem_wdata, mem_dmem_out;
  logic [3:0] dmem_be;
  int checks = 0, errors = 0;

  typedef struct {
    logic we; logic [3:0] be; logic [31:0] addr, wdata, dout;
    logic chk_wdata, err; int stall, req;
  } exp_t;
  exp_t q[$];

  pipe_mem_dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_dmem_op(mem_dmem_op),
    .mem_alu_out(mem_alu_out), .mem_rt_data(mem_rt_data), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .mem_dmem_out(mem_dmem_out),
    .mem_stall(mem_stall), .mem_addr_exc(mem_addr_exc), .mem_bus_err(mem_bus_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ack_at: BUSY cycle (1-based) carrying the ack, 0 for none (timeout after 4)
  task automatic access(input logic [3:0] op, input logic [31:0] a, rt, rd, input int ack_at,
                        input logic [3:0] be, input logic [31:0] wd, dout, input logic err);
    exp_t e;
    int nb;
    nb = ack_at > 0 ? ack_at : 4;
    e.we = op >= 6; e.be = be; e.addr = {a[31:2], 2'b00}; e.wdata = wd; e.dout = dout;
    e.chk_wdata = op >= 6; e.err = err; e.stall = nb + 1; e.req = nb;
    q.push_back(e);
    @(posedge clk); #1;
    mem_valid = 1; mem_dmem_op = op; mem_alu_out = a; mem_rt_data = rt; dmem_rdata = rd;
    for (int k = 1; k <= nb; k++) begin
      @(posedge clk); #1;
      mem_valid = 0;
      dmem_ack = (k == ack_at);
    end
    @(posedge clk); #1;
    dmem_ack = 0; mem_dmem_op = 0;
    @(posedge clk); #1;
  endtask

  // monitor: counts stall/req cycles and checks the result in the DONE cycle
  int scnt = 0, rcnt = 0;
  logic prev_stall = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0] cap_be;
  logic cap_we;
  always @(negedge clk) begin
    if (!rst) begin
      scnt = 0; rcnt = 0; prev_stall = 0;
    end else begin
      if (dmem_req) begin
        if (rcnt == 0) begin
          cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
        end
        rcnt++;
      end
      if (mem_stall) scnt++;
      if (prev_stall && !mem_stall) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          exp_t e;
          e = q.pop_front();
          check("we", 32'(cap_we), 32'(e.we));
          check("be", 32'(cap_be), 32'(e.be));
          check("addr", cap_addr, e.addr);
          if (e.chk_wdata) check("wdata", cap_wdata, e.wdata);
          check("dout", mem_dmem_out, e.dout);
          check("bus_err", 32'(mem_bus_err), 32'(e.err));
          check("stall_cycles", 32'(scnt), 32'(e.stall));
          check("req_cycles", 32'(rcnt), 32'(e.req));
        end
        scnt = 0; rcnt = 0;
      end
      prev_stall = mem_stall;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_req", 32'(dmem_req), 0);
    check("rst_stall", 32'(mem_stall), 0);
    check("rst_dout", mem_dmem_out, 0);
    rst = 1;
    @(posedge clk); #1;
    check("idle_err", 32'(mem_bus_err), 0);
    check("idle_be", 32'(dmem_be), 0);
    access(4'd1, 32'h100, 32'h0, 32'hDEADBEEF, 1, 4'hF, 32'h0, 32'hDEADBEEF, 0);
    access(4'd4, 32'h103, 32'h0, 32'h80FF1234, 3, 4'h8, 32'h0, 32'hFFFFFF80, 0);
    access(4'd5, 32'h103, 32'h0, 32'h80FF1234, 3, 4'h8, 32'h0, 32'h00000080, 0);
    access(4'd7, 32'h202, 32'h1234ABCD, 32'h55555555, 1, 4'hC, 32'hABCDABCD, 32'h00000080, 0);
    access(4'd2, 32'h102, 32'h0, 32'h80FF1234, 2, 4'hC, 32'h0, 32'hFFFF80FF, 0);
    access(4'd3, 32'h100, 32'h0, 32'h80FF1234, 1, 4'h3, 32'h0, 32'h00001234, 0);
    access(4'd8, 32'h101, 32'h000000A5, 32'h0, 2, 4'h2, 32'hA5A5A5A5, 32'h00001234, 0);
    access(4'd6, 32'h104, 32'hCAFEF00D, 32'h0, 1, 4'hF, 32'hCAFEF00D, 32'h00001234, 0);
    access(4'd1, 32'h108, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h0, 1);
    access(4'd1, 32'h10C, 32'h0, 32'h11223344, 4, 4'hF, 32'h0, 32'h11223344, 0);
    // misaligned accesses: exception, no stall, no request
    mem_valid = 1; mem_dmem_op = 4'd1; mem_alu_out = 32'h101; #1;
    check("mis_lw_exc", 32'(mem_addr_exc), 1);
    check("mis_lw_stall", 32'(mem_stall), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("mis_lw_req", 32'(dmem_req), 0);
    end
    mem_dmem_op = 4'd2; mem_alu_out = 32'h103; #1;
    check("mis_lh_exc", 32'(mem_addr_exc), 1);
    mem_dmem_op = 4'd6; mem_alu_out = 32'h102; #1;
    check("mis_sw_exc", 32'(mem_addr_exc), 1);
    mem_dmem_op = 4'd9; #1;
    check("op9_exc", 32'(mem_addr_exc), 0);
    check("op9_stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    check("op9_req", 32'(dmem_req), 0);
    mem_valid = 0; mem_dmem_op = 0;
    // reset in the middle of BUSY
    @(posedge clk); #1;
    mem_valid = 1; mem_dmem_op = 4'd1; mem_alu_out = 32'h200;
    @(posedge clk); #1;
    mem_valid = 0; mem_dmem_op = 0;
    @(posedge clk); #1;
    check("busy_req", 32'(dmem_req), 1);
    rst = 0; #1;
    check("mid_rst_req", 32'(dmem_req), 0);
    check("mid_rst_stall", 32'(mem_stall), 0);
    check("mid_rst_dout", mem_dmem_out, 0);
    @(posedge clk); #1;
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_rst_req", 32'(dmem_req), 0);
      check("post_rst_err", 32'(mem_bus_err), 0);
      check("post_rst_stall", 32'(mem_stall), 0);
    end
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    check("scoreboard_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
